// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions: sequencer state encoding, next-PC selects, opcodes.
package rv32i_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_IWAIT  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MREQ   = 3'd4,
        ST_MWAIT  = 3'd5,
        ST_WB     = 3'd6,
        ST_HALT   = 3'd7
    } seq_state_t;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JAL    = 2'd2;
    localparam logic [1:0] PC_JALR   = 2'd3;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    // A decode is legal only when exactly one class enable is set.
    function automatic logic is_one_hot(input logic [9:0] v);
        return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
    endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Instruction and data memory handshakes between the sequencer and the memory side.
interface core_sequencer_if;
    logic imem_req;
    logic imem_ready;
    logic imem_rvalid;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;
    logic dmem_rvalid;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_ready, imem_rvalid, dmem_ready, dmem_rvalid
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_ready, imem_rvalid, dmem_ready, dmem_rvalid
    );
endinterface

// File: rtl/core_sequencer_timeout.sv
// Loadable, clearable wait counter; terminal is high on the last permitted wait cycle.
module seq_timeout_counter #(
    parameter int MEM_TIMEOUT = 16,
    localparam int CW = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          enable,
    output logic          terminal
);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (enable) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    // This cycle would make the count reach MEM_TIMEOUT.
    assign terminal = (count_reg == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle rv32i control FSM: fetch, decode bubble, execute, memory access, writeback.
module core_sequencer
    import rv32i_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 hold,
    core_sequencer_if.master     mem,
    output logic                 ir_load,
    input  logic                 dec_branch,
    input  logic                 dec_jalr,
    input  logic                 dec_jal,
    input  logic                 dec_lui,
    input  logic                 dec_auipc,
    input  logic                 dec_reg_imm,
    input  logic                 dec_reg_reg,
    input  logic                 dec_load,
    input  logic                 dec_store,
    input  logic                 dec_fence,
    input  logic                 branch_taken,
    output logic                 regfile_we,
    output logic                 pc_write,
    output logic [1:0]           pc_sel,
    output logic                 illegal,
    output logic                 timeout_err,
    output logic [CNT_WIDTH-1:0] retired,
    output logic [2:0]           state
);

    seq_state_t           state_reg, state_next;
    logic                 illegal_reg, timeout_reg, store_reg;
    logic [CNT_WIDTH-1:0] retired_reg;
    logic                 set_illegal, set_timeout, retire, wait_active, wait_tc;
    logic                 imem_req, dmem_req, dmem_we;
    logic [9:0]           dec_vec;

    assign dec_vec = {dec_fence, dec_store, dec_load, dec_reg_reg, dec_reg_imm,
                      dec_auipc, dec_lui, dec_jal, dec_jalr, dec_branch};

    seq_timeout_counter #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (state_next != state_reg),
        .load       (1'b0),
        .load_value ('0),
        .enable     (wait_active),
        .terminal   (wait_tc)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_FETCH;
            illegal_reg <= 1'b0;
            timeout_reg <= 1'b0;
            store_reg   <= 1'b0;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (set_illegal) illegal_reg <= 1'b1;
            if (set_timeout) timeout_reg <= 1'b1;
            if (retire)      retired_reg <= retired_reg + CNT_WIDTH'(1);
            if (state_reg == ST_EXEC) store_reg <= dec_store;
        end
    end

    always_comb begin
        state_next  = state_reg;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        ir_load     = 1'b0;
        regfile_we  = 1'b0;
        pc_write    = 1'b0;
        pc_sel      = PC_PLUS4;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        retire      = 1'b0;
        wait_active = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                // No fetch request while reset is held; hold freezes the FSM here.
                if (!hold && reset_n) begin
                    imem_req    = 1'b1;
                    wait_active = 1'b1;
                    if (mem.imem_ready) begin
                        state_next = ST_IWAIT;
                    end else if (wait_tc) begin
                        set_timeout = 1'b1;
                        state_next  = ST_HALT;
                    end
                end
            end
            ST_IWAIT: begin
                wait_active = 1'b1;
                if (mem.imem_rvalid) begin
                    ir_load    = 1'b1;
                    state_next = ST_DECODE;
                end else if (wait_tc) begin
                    set_timeout = 1'b1;
                    state_next  = ST_HALT;
                end
            end
            ST_DECODE: state_next = ST_EXEC;
            ST_EXEC: begin
                if (!is_one_hot(dec_vec)) begin
                    set_illegal = 1'b1;
                    state_next  = ST_HALT;
                end else if (dec_load || dec_store) begin
                    state_next = ST_MREQ;
                end else begin
                    pc_write = 1'b1;
                    if (dec_branch && branch_taken) pc_sel = PC_BRANCH;
                    else if (dec_jal)               pc_sel = PC_JAL;
                    else if (dec_jalr)              pc_sel = PC_JALR;
                    regfile_we = dec_lui | dec_auipc | dec_reg_imm | dec_reg_reg | dec_jal | dec_jalr;
                    retire     = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_MREQ: begin
                dmem_req    = 1'b1;
                dmem_we     = store_reg;
                wait_active = 1'b1;
                if (mem.dmem_ready) begin
                    state_next = ST_MWAIT;
                end else if (wait_tc) begin
                    set_timeout = 1'b1;
                    state_next  = ST_HALT;
                end
            end
            ST_MWAIT: begin
                wait_active = 1'b1;
                if (mem.dmem_rvalid) begin
                    state_next = ST_WB;
                end else if (wait_tc) begin
                    set_timeout = 1'b1;
                    state_next  = ST_HALT;
                end
            end
            ST_WB: begin
                regfile_we = !store_reg;
                pc_write   = 1'b1;
                retire     = 1'b1;
                state_next = ST_FETCH;
            end
            default: state_next = ST_HALT;
        endcase
    end

    assign mem.imem_req = imem_req;
    assign mem.dmem_req = dmem_req;
    assign mem.dmem_we  = dmem_we;
    assign illegal      = illegal_reg;
    assign timeout_err  = timeout_reg;
    assign retired      = retired_reg;
    assign state        = state_reg;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: instruction classes, memory stalls, illegal, timeout, reset.
module tb_core_sequencer;
    import rv32i_pkg::*;

    // dec_vec bit order: branch, jalr, jal, lui, auipc, reg_imm, reg_reg, load, store, fence
    localparam logic [9:0] D_BRANCH  = 10'b00_0000_0001;
    localparam logic [9:0] D_JALR    = 10'b00_0000_0010;
    localparam logic [9:0] D_JAL     = 10'b00_0000_0100;
    localparam logic [9:0] D_LUI     = 10'b00_0000_1000;
    localparam logic [9:0] D_AUIPC   = 10'b00_0001_0000;
    localparam logic [9:0] D_REG_IMM = 10'b00_0010_0000;
    localparam logic [9:0] D_REG_REG = 10'b00_0100_0000;
    localparam logic [9:0] D_LOAD    = 10'b00_1000_0000;
    localparam logic [9:0] D_STORE   = 10'b01_0000_0000;
    localparam logic [9:0] D_FENCE   = 10'b10_0000_0000;

    logic        clock, reset_n, hold, branch_taken;
    logic [9:0]  dec_vec;
    logic        ir_load, regfile_we, pc_write, illegal, timeout_err;
    logic [1:0]  pc_sel;
    logic [31:0] retired;
    logic [2:0]  state;
    int          checks = 0;
    int          errors = 0;
    int          exp_retired = 0;
    int          cyc;

    core_sequencer_if mem_if();

    core_sequencer #(.MEM_TIMEOUT(16), .CNT_WIDTH(32)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .hold         (hold),
        .mem          (mem_if),
        .ir_load      (ir_load),
        .dec_branch   (dec_vec[0]),
        .dec_jalr     (dec_vec[1]),
        .dec_jal      (dec_vec[2]),
        .dec_lui      (dec_vec[3]),
        .dec_auipc    (dec_vec[4]),
        .dec_reg_imm  (dec_vec[5]),
        .dec_reg_reg  (dec_vec[6]),
        .dec_load     (dec_vec[7]),
        .dec_store    (dec_vec[8]),
        .dec_fence    (dec_vec[9]),
        .branch_taken (branch_taken),
        .regfile_we   (regfile_we),
        .pc_write     (pc_write),
        .pc_sel       (pc_sel),
        .illegal      (illegal),
        .timeout_err  (timeout_err),
        .retired      (retired),
        .state        (state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // Runs one instruction from FETCH back to FETCH with the given memory delays.
    task automatic run_instr(input string name, input logic [9:0] dec, input logic taken,
                             input int iwait, input int rdy_dly, input int rv_dly,
                             input logic [1:0] exp_sel, input logic exp_we, output int cycles);
        logic is_mem, is_store;
        int   req_cnt;
        is_mem   = dec[7] | dec[8];
        is_store = dec[8];
        cycles   = 0;
        mem_if.imem_ready = 1'b1;
        #1;
        check_eq({name, " fetch state"}, 32'(state), 32'(ST_FETCH));
        check_eq({name, " imem_req"}, 32'(mem_if.imem_req), 32'd1);
        tick(); cycles++;
        mem_if.imem_ready = 1'b0;
        for (int i = 0; i < iwait; i++) begin
            #1;
            check_eq({name, " iwait ir_load"}, 32'(ir_load), 32'd0);
            tick(); cycles++;
        end
        mem_if.imem_rvalid = 1'b1;
        #1;
        check_eq({name, " iwait state"}, 32'(state), 32'(ST_IWAIT));
        check_eq({name, " ir_load"}, 32'(ir_load), 32'd1);
        tick(); cycles++;
        mem_if.imem_rvalid = 1'b0;
        dec_vec      = dec;
        branch_taken = taken;
        #1;
        check_eq({name, " decode state"}, 32'(state), 32'(ST_DECODE));
        tick(); cycles++;
        #1;
        check_eq({name, " exec state"}, 32'(state), 32'(ST_EXEC));
        if (is_mem) begin
            check_eq({name, " exec pc_write"}, 32'(pc_write), 32'd0);
            tick(); cycles++;
            req_cnt = 0;
            for (int i = 0; i <= rdy_dly; i++) begin
                if (i == rdy_dly) mem_if.dmem_ready = 1'b1;
                #1;
                check_eq({name, " mreq state"}, 32'(state), 32'(ST_MREQ));
                check_eq({name, " dmem_we"}, 32'(mem_if.dmem_we), 32'(is_store));
                if (mem_if.dmem_req) req_cnt++;
                tick(); cycles++;
                mem_if.dmem_ready = 1'b0;
            end
            check_eq({name, " dmem_req cycles"}, 32'(req_cnt), 32'(rdy_dly + 1));
            for (int i = 0; i < rv_dly; i++) begin
                if (i == rv_dly - 1) mem_if.dmem_rvalid = 1'b1;
                #1;
                check_eq({name, " mwait state"}, 32'(state), 32'(ST_MWAIT));
                check_eq({name, " mwait regfile_we"}, 32'(regfile_we), 32'd0);
                tick(); cycles++;
                mem_if.dmem_rvalid = 1'b0;
            end
            #1;
            check_eq({name, " wb state"}, 32'(state), 32'(ST_WB));
        end
        check_eq({name, " pc_write"}, 32'(pc_write), 32'd1);
        check_eq({name, " pc_sel"}, 32'(pc_sel), 32'(exp_sel));
        check_eq({name, " regfile_we"}, 32'(regfile_we), 32'(exp_we));
        tick(); cycles++;
        exp_retired++;
        #1;
        check_eq({name, " retired"}, retired, 32'(exp_retired));
        check_eq({name, " back to fetch"}, 32'(state), 32'(ST_FETCH));
        check_eq({name, " regfile_we low"}, 32'(regfile_we), 32'd0);
        $display("txn %-6s cycles=%0d retired=%0d", name, cycles, retired);
    endtask

    // Drives an instruction whose class enables are not one-hot; expects HALT.
    task automatic run_illegal(input string name, input logic [9:0] dec);
        mem_if.imem_ready = 1'b1;
        tick();
        mem_if.imem_ready  = 1'b0;
        mem_if.imem_rvalid = 1'b1;
        tick();
        mem_if.imem_rvalid = 1'b0;
        dec_vec = dec;
        tick();
        #1;
        check_eq({name, " exec state"}, 32'(state), 32'(ST_EXEC));
        check_eq({name, " exec pc_write"}, 32'(pc_write), 32'd0);
        check_eq({name, " exec regfile_we"}, 32'(regfile_we), 32'd0);
        tick();
        #1;
        check_eq({name, " illegal"}, 32'(illegal), 32'd1);
        check_eq({name, " halt state"}, 32'(state), 32'(ST_HALT));
        mem_if.imem_ready = 1'b1;
        repeat (3) tick();
        #1;
        check_eq({name, " halt sticky"}, 32'(state), 32'(ST_HALT));
        check_eq({name, " halt imem_req"}, 32'(mem_if.imem_req), 32'd0);
        check_eq({name, " halt retired"}, retired, 32'(exp_retired));
        mem_if.imem_ready = 1'b0;
        $display("txn %-6s halted illegal=%0d", name, illegal);
    endtask

    // Asserts reset_n between clock edges and expects everything cleared before the next edge.
    task automatic async_reset(input string name);
        #2 reset_n = 1'b0;
        #1;
        check_eq({name, " rst state"}, 32'(state), 32'(ST_FETCH));
        check_eq({name, " rst illegal"}, 32'(illegal), 32'd0);
        check_eq({name, " rst timeout"}, 32'(timeout_err), 32'd0);
        check_eq({name, " rst retired"}, retired, 32'd0);
        exp_retired = 0;
        tick();
        dec_vec = '0;
        reset_n = 1'b1;
        $display("txn %-6s reset", name);
    endtask

    logic [9:0] alu_dec [4] = '{D_LUI, D_AUIPC, D_REG_IMM, D_FENCE};
    logic       alu_we  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    string      alu_nm  [4] = '{"LUI", "AUIPC", "ADDI", "FENCE"};

    initial begin
        int req_seen;
        reset_n = 1'b0;
        hold = 1'b0;
        branch_taken = 1'b0;
        dec_vec = '0;
        mem_if.imem_ready  = 1'b0;
        mem_if.imem_rvalid = 1'b0;
        mem_if.dmem_ready  = 1'b0;
        mem_if.dmem_rvalid = 1'b0;
        tick();
        #1;
        check_eq("reset state", 32'(state), 32'(ST_FETCH));
        check_eq("reset imem_req", 32'(mem_if.imem_req), 32'd0);
        check_eq("reset dmem_req", 32'(mem_if.dmem_req), 32'd0);
        check_eq("reset strobes", {29'd0, ir_load, regfile_we, pc_write}, 32'd0);
        check_eq("reset pc_sel", 32'(pc_sel), 32'd0);
        check_eq("reset flags", {30'd0, illegal, timeout_err}, 32'd0);
        check_eq("reset retired", retired, 32'd0);
        tick();
        reset_n = 1'b1;

        // Hold longer than the timeout: frozen in FETCH, no request, no timeout.
        hold = 1'b1;
        mem_if.imem_ready = 1'b1;
        req_seen = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (mem_if.imem_req) req_seen++;
            tick();
        end
        #1;
        check_eq("hold imem_req cycles", 32'(req_seen), 32'd0);
        check_eq("hold state", 32'(state), 32'(ST_FETCH));
        check_eq("hold timeout", 32'(timeout_err), 32'd0);
        hold = 1'b0;
        mem_if.imem_ready = 1'b0;
        $display("txn HOLD   frozen 20 cycles");

        run_instr("ADD", D_REG_REG, 1'b0, 0, 0, 0, PC_PLUS4, 1'b1, cyc);
        check_eq("ADD cycles", 32'(cyc), 32'd4);
        run_instr("ADD_T", D_REG_REG, 1'b1, 0, 0, 0, PC_PLUS4, 1'b1, cyc);
        run_instr("BEQ_T", D_BRANCH, 1'b1, 0, 0, 0, PC_BRANCH, 1'b0, cyc);
        run_instr("BEQ_N", D_BRANCH, 1'b0, 0, 0, 0, PC_PLUS4, 1'b0, cyc);
        // FETCH+IWAIT+DECODE+EXEC (4) + MREQ (4) + MWAIT (2) + WB (1)
        run_instr("LW", D_LOAD, 1'b0, 0, 3, 2, PC_PLUS4, 1'b1, cyc);
        check_eq("LW cycles", 32'(cyc), 32'd11);
        run_instr("SW", D_STORE, 1'b0, 0, 1, 1, PC_PLUS4, 1'b0, cyc);
        check_eq("SW cycles", 32'(cyc), 32'd8);
        run_instr("JAL", D_JAL, 1'b0, 0, 0, 0, PC_JAL, 1'b1, cyc);
        run_instr("JALR", D_JALR, 1'b1, 0, 0, 0, PC_JALR, 1'b1, cyc);
        for (int i = 0; i < 4; i++)
            run_instr(alu_nm[i], alu_dec[i], 1'b0, 0, 0, 0, PC_PLUS4, alu_we[i], cyc);
        check_eq("retired after sequence", retired, 32'd12);

        // rvalid on the 16th IWAIT cycle arrives with the timeout and wins.
        run_instr("LATE16", D_REG_IMM, 1'b0, 15, 0, 0, PC_PLUS4, 1'b1, cyc);
        check_eq("LATE16 cycles", 32'(cyc), 32'd19);
        check_eq("LATE16 no timeout", 32'(timeout_err), 32'd0);

        run_illegal("MULTI", D_REG_REG | D_LOAD);
        async_reset("RST1");
        run_illegal("NONE", 10'd0);
        async_reset("RST2");

        // imem_rvalid never arrives: timeout after 16 IWAIT cycles.
        mem_if.imem_ready = 1'b1;
        tick();
        mem_if.imem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (i == 15) begin
                check_eq("TO iwait state", 32'(state), 32'(ST_IWAIT));
                check_eq("TO not yet", 32'(timeout_err), 32'd0);
            end
            tick();
        end
        #1;
        check_eq("TO timeout_err", 32'(timeout_err), 32'd1);
        check_eq("TO halt state", 32'(state), 32'(ST_HALT));
        check_eq("TO illegal clear", 32'(illegal), 32'd0);
        repeat (2) tick();
        #1;
        check_eq("TO halt sticky", 32'(state), 32'(ST_HALT));
        $display("txn TMOUT  halted timeout_err=%0d", timeout_err);
        async_reset("RST3");

        run_instr("ADD2", D_REG_REG, 1'b0, 0, 0, 0, PC_PLUS4, 1'b1, cyc);
        check_eq("ADD2 cycles", 32'(cyc), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
